// File: rtl/ps2_pad_responder_if.sv
// PS2 pad serial link: host attention/clock/command and pad data/acknowledge.
// The host poller uses the master side, the pad emulator the slave side.
interface ps2_pad_responder_if;
    logic pad_att_n;   // host attention, active low
    logic pad_clk;     // host serial clock, idles high
    logic pad_cmd;     // host command bit, LSB first
    logic pad_dat;     // pad response bit, LSB first
    logic pad_dat_oe;  // pad drive enable for the open-drain data buffer
    logic pad_ack_n;   // pad acknowledge, active low

    modport master (
        output pad_att_n,
        output pad_clk,
        output pad_cmd,
        input  pad_dat,
        input  pad_dat_oe,
        input  pad_ack_n
    );

    modport slave (
        input  pad_att_n,
        input  pad_clk,
        input  pad_cmd,
        output pad_dat,
        output pad_dat_oe,
        output pad_ack_n
    );
endinterface

// File: rtl/ps2_pad_responder.sv
// PlayStation-style game pad emulator (device end of the PS2 pad link).
// Answers poll (0x42), config enter/exit (0x43) and analog-mode set (0x44).
module ps2_pad_responder #(
    parameter int unsigned ACK_DELAY = 4,  // clks from completed byte to ack_n low
    parameter int unsigned ACK_WIDTH = 2   // clks ack_n is held low
) (
    input  logic                 clk,
    input  logic                 reset,
    ps2_pad_responder_if.slave   pad,
    input  logic [15:0]          buttons,
    input  logic [31:0]          analog,
    output logic                 mode_analog,
    output logic                 config_mode,
    output logic                 cmd_valid,
    output logic [7:0]           cmd_byte
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_ACK_WAIT,
        S_ACK,
        S_DONE
    } state_t;

    // synchronised host inputs
    logic att_m, att_s;
    logic clk_m, clk_s, clk_d;
    logic cmd_m, cmd_s;
    logic clk_rise, clk_fall;

    // registered state and next values
    state_t     state_q,      state_n;
    logic [3:0] byte_idx_q,   byte_idx_n;
    logic [2:0] bit_cnt_q,    bit_cnt_n;
    logic [7:0] tx_q,         tx_n;
    logic [6:0] rx_q,         rx_n;
    logic [7:0] cnt_q,        cnt_n;
    logic [7:0] pkt_cmd_q,    pkt_cmd_n;
    logic       pend_cfg_q,   pend_cfg_n;
    logic       pend_cfg_v_q, pend_cfg_v_n;
    logic       pend_ana_q,   pend_ana_n;
    logic       pend_ana_v_q, pend_ana_v_n;
    logic       pkt_ok_q,     pkt_ok_n;
    logic       dat_q,        dat_n;
    logic       dat_oe_q,     dat_oe_n;
    logic       ack_n_q,      ack_n_n;
    logic       ana_q,        ana_n;
    logic       cfg_q,        cfg_n;
    logic       cv_q,         cv_n;
    logic [7:0] cb_q,         cb_n;

    // derived values
    logic [7:0] rx_full;
    logic [7:0] id_byte;
    logic [3:0] last_idx;
    logic [3:0] next_idx;
    logic       data_is_pad;
    logic [7:0] next_tx;

    // Two-stage synchronisers on the host inputs plus a delayed clock for edge detect
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            att_m <= 1'b1;
            att_s <= 1'b1;
            clk_m <= 1'b1;
            clk_s <= 1'b1;
            clk_d <= 1'b1;
            cmd_m <= 1'b0;
            cmd_s <= 1'b0;
        end else begin
            att_m <= pad.pad_att_n;
            att_s <= att_m;
            clk_m <= pad.pad_clk;
            clk_s <= clk_m;
            clk_d <= clk_s;
            cmd_m <= pad.pad_cmd;
            cmd_s <= cmd_m;
        end
    end

    assign clk_rise = clk_s & ~clk_d;
    assign clk_fall = ~clk_s & clk_d;

    // Byte being completed on this rising edge (LSB first, newest bit at the top)
    assign rx_full = {cmd_s, rx_q};

    // Response ID and packet length follow the modes that were active at packet start
    always_comb begin
        if (cfg_q)      id_byte = 8'hF3;
        else if (ana_q) id_byte = 8'h73;
        else            id_byte = 8'h41;
        last_idx = {id_byte[2:0], 1'b0} + 4'd2;
    end

    // Next transmit byte, loaded while waiting to acknowledge the current one
    always_comb begin
        next_idx    = byte_idx_q + 4'd1;
        data_is_pad = (pkt_cmd_q == 8'h42) || ((pkt_cmd_q == 8'h43) && !cfg_q);
        next_tx     = 8'h00;
        case (next_idx)
            4'd0: next_tx = 8'hFF;
            4'd1: next_tx = id_byte;
            4'd2: next_tx = 8'h5A;
            4'd3: next_tx = data_is_pad ? ~buttons[7:0]  : 8'h00;
            4'd4: next_tx = data_is_pad ? ~buttons[15:8] : 8'h00;
            4'd5: next_tx = data_is_pad ? analog[7:0]    : 8'h00;
            4'd6: next_tx = data_is_pad ? analog[15:8]   : 8'h00;
            4'd7: next_tx = data_is_pad ? analog[23:16]  : 8'h00;
            4'd8: next_tx = data_is_pad ? analog[31:24]  : 8'h00;
            default: next_tx = 8'h00;
        endcase
    end

    // State register and all protocol/datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            byte_idx_q   <= '0;
            bit_cnt_q    <= '0;
            tx_q         <= '1;
            rx_q         <= '0;
            cnt_q        <= '0;
            pkt_cmd_q    <= '0;
            pend_cfg_q   <= 1'b0;
            pend_cfg_v_q <= 1'b0;
            pend_ana_q   <= 1'b0;
            pend_ana_v_q <= 1'b0;
            pkt_ok_q     <= 1'b0;
            dat_q        <= 1'b1;
            dat_oe_q     <= 1'b0;
            ack_n_q      <= 1'b1;
            ana_q        <= 1'b0;
            cfg_q        <= 1'b0;
            cv_q         <= 1'b0;
            cb_q         <= '0;
        end else begin
            state_q      <= state_n;
            byte_idx_q   <= byte_idx_n;
            bit_cnt_q    <= bit_cnt_n;
            tx_q         <= tx_n;
            rx_q         <= rx_n;
            cnt_q        <= cnt_n;
            pkt_cmd_q    <= pkt_cmd_n;
            pend_cfg_q   <= pend_cfg_n;
            pend_cfg_v_q <= pend_cfg_v_n;
            pend_ana_q   <= pend_ana_n;
            pend_ana_v_q <= pend_ana_v_n;
            pkt_ok_q     <= pkt_ok_n;
            dat_q        <= dat_n;
            dat_oe_q     <= dat_oe_n;
            ack_n_q      <= ack_n_n;
            ana_q        <= ana_n;
            cfg_q        <= cfg_n;
            cv_q         <= cv_n;
            cb_q         <= cb_n;
        end
    end

    // Next-state and output logic for the packet FSM
    always_comb begin
        state_n      = state_q;
        byte_idx_n   = byte_idx_q;
        bit_cnt_n    = bit_cnt_q;
        tx_n         = tx_q;
        rx_n         = rx_q;
        cnt_n        = cnt_q;
        pkt_cmd_n    = pkt_cmd_q;
        pend_cfg_n   = pend_cfg_q;
        pend_cfg_v_n = pend_cfg_v_q;
        pend_ana_n   = pend_ana_q;
        pend_ana_v_n = pend_ana_v_q;
        pkt_ok_n     = pkt_ok_q;
        dat_n        = dat_q;
        dat_oe_n     = dat_oe_q;
        ack_n_n      = ack_n_q;
        ana_n        = ana_q;
        cfg_n        = cfg_q;
        cv_n         = 1'b0;
        cb_n         = cb_q;

        case (state_q)
            S_IDLE: begin
                dat_n    = 1'b1;
                dat_oe_n = 1'b0;
                ack_n_n  = 1'b1;
                if (!att_s) begin
                    state_n      = S_SHIFT;
                    byte_idx_n   = '0;
                    bit_cnt_n    = '0;
                    tx_n         = 8'hFF;
                    dat_n        = 1'b1;
                    dat_oe_n     = 1'b1;
                    pend_cfg_v_n = 1'b0;
                    pend_ana_v_n = 1'b0;
                    pkt_ok_n     = 1'b0;
                end
            end

            S_SHIFT: begin
                if (att_s) begin
                    state_n      = S_IDLE;
                    dat_n        = 1'b1;
                    dat_oe_n     = 1'b0;
                    ack_n_n      = 1'b1;
                    pend_cfg_v_n = 1'b0;
                    pend_ana_v_n = 1'b0;
                    pkt_ok_n     = 1'b0;
                end else if (clk_fall) begin
                    // Re-presenting the current bit keeps bit 0 correct on the first fall
                    dat_n = tx_q[bit_cnt_q];
                end else if (clk_rise) begin
                    rx_n = rx_full[7:1];
                    if (bit_cnt_q != 3'd7) begin
                        bit_cnt_n = bit_cnt_q + 3'd1;
                    end else begin
                        cv_n      = 1'b1;
                        cb_n      = rx_full;
                        bit_cnt_n = '0;
                        cnt_n     = '0;
                        state_n   = S_ACK_WAIT;
                        if (byte_idx_q == last_idx) begin
                            state_n  = S_DONE;
                            pkt_ok_n = 1'b1;
                        end
                        case (byte_idx_q)
                            4'd0: begin
                                if (rx_full != 8'h01) state_n = S_DONE;
                            end
                            4'd1: begin
                                pkt_cmd_n = rx_full;
                                if (!cfg_q && (rx_full != 8'h42) && (rx_full != 8'h43))
                                    state_n = S_DONE;
                            end
                            4'd3: begin
                                if (pkt_cmd_q == 8'h43) begin
                                    if (rx_full == 8'h01) begin
                                        pend_cfg_n   = 1'b1;
                                        pend_cfg_v_n = 1'b1;
                                    end else if (rx_full == 8'h00) begin
                                        pend_cfg_n   = 1'b0;
                                        pend_cfg_v_n = 1'b1;
                                    end
                                end else if ((pkt_cmd_q == 8'h44) && cfg_q) begin
                                    if (rx_full == 8'h01) begin
                                        pend_ana_n   = 1'b1;
                                        pend_ana_v_n = 1'b1;
                                    end else if (rx_full == 8'h00) begin
                                        pend_ana_n   = 1'b0;
                                        pend_ana_v_n = 1'b1;
                                    end
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end

            S_ACK_WAIT: begin
                if (att_s) begin
                    state_n      = S_IDLE;
                    dat_n        = 1'b1;
                    dat_oe_n     = 1'b0;
                    ack_n_n      = 1'b1;
                    pend_cfg_v_n = 1'b0;
                    pend_ana_v_n = 1'b0;
                    pkt_ok_n     = 1'b0;
                end else if (cnt_q == 8'(ACK_DELAY - 1)) begin
                    state_n = S_ACK;
                    cnt_n   = '0;
                    ack_n_n = 1'b0;
                    tx_n    = next_tx;
                end else begin
                    cnt_n = cnt_q + 8'd1;
                end
            end

            S_ACK: begin
                if (att_s) begin
                    state_n      = S_IDLE;
                    dat_n        = 1'b1;
                    dat_oe_n     = 1'b0;
                    ack_n_n      = 1'b1;
                    pend_cfg_v_n = 1'b0;
                    pend_ana_v_n = 1'b0;
                    pkt_ok_n     = 1'b0;
                end else if (cnt_q == 8'(ACK_WIDTH - 1)) begin
                    state_n    = S_SHIFT;
                    ack_n_n    = 1'b1;
                    byte_idx_n = byte_idx_q + 4'd1;
                    bit_cnt_n  = '0;
                    dat_n      = tx_q[0];
                end else begin
                    cnt_n = cnt_q + 8'd1;
                end
            end

            S_DONE: begin
                dat_n    = 1'b1;
                dat_oe_n = 1'b0;
                ack_n_n  = 1'b1;
                if (att_s) begin
                    state_n = S_IDLE;
                    if (pkt_ok_q) begin
                        if (pend_cfg_v_q) cfg_n = pend_cfg_q;
                        if (pend_ana_v_q) ana_n = pend_ana_q;
                    end
                    pend_cfg_v_n = 1'b0;
                    pend_ana_v_n = 1'b0;
                    pkt_ok_n     = 1'b0;
                end
            end

            default: begin
                state_n  = S_IDLE;
                dat_n    = 1'b1;
                dat_oe_n = 1'b0;
                ack_n_n  = 1'b1;
            end
        endcase
    end

    assign pad.pad_dat    = dat_q;
    assign pad.pad_dat_oe = dat_oe_q;
    assign pad.pad_ack_n  = ack_n_q;
    assign mode_analog    = ana_q;
    assign config_mode    = cfg_q;
    assign cmd_valid      = cv_q;
    assign cmd_byte       = cb_q;

endmodule

// File: doc/ps2_pad_responder.md
Name: ps2_pad_responder

Overview:
- Emulates a PlayStation-style game pad on the controller side of the PS2 pad serial link. This is the device end of the same attention/clock/command/data protocol our host poller drives.
- Accepts host attention, clock and command. Returns header, button and analog bytes on data, and pulses acknowledge after each non-final byte.
- Used as a bench/loopback target for the host poller and as a pad emulator driven by board switches.
- Supports poll (0x42), config enter/exit (0x43) and analog-mode set (0x44).

Parameters:
- ACK_DELAY, 4: clk cycles from the 8th rising pad_clk edge of a byte to ack_n assertion.
- ACK_WIDTH, 2: clk cycles ack_n is held low.

Ports:
- clk  input  1  system clock; must be ≥8× the pad_clk frequency.
- reset  input  1  asynchronous, active-high reset.
- pad_att_n  input  1  host attention, active low; frames a packet.
- pad_clk  input  1  host serial clock; idles high.
- pad_cmd  input  1  host command bit, LSB first.
- pad_dat  output  1  response bit, LSB first.
- pad_dat_oe  output  1  drive enable for pad_dat; board uses an open-drain buffer.
- pad_ack_n  output  1  acknowledge, active low.
- buttons  input  16  pressed = 1. Bits [7:0] map to data byte 0, bits [15:8] to data byte 1.
- analog  input  32  four stick bytes: [7:0]=RX, [15:8]=RY, [23:16]=LX, [31:24]=LY.
- mode_analog  output  1  1 = analog mode active.
- config_mode  output  1  1 = config mode active.
- cmd_valid  output  1  one-clk strobe when a command byte completes.
- cmd_byte  output  8  last completed command byte; valid with cmd_valid.

Behaviour:
- Reset values: pad_dat=1, pad_dat_oe=0, pad_ack_n=1, mode_analog=0, config_mode=0, cmd_valid=0, cmd_byte=0x00. FSM goes to IDLE.
- Input synchronisation: pad_att_n, pad_clk and pad_cmd pass through 2-FF synchronisers. Edges are detected on the synchronised pad_clk.
- FSM states:
  - IDLE: waits for synchronised att_n low. Then byte_idx=0, loads tx byte 0xFF, pad_dat_oe=1, goes to SHIFT.
  - SHIFT: on pad_clk falling edge, present next tx bit on pad_dat (bit 0 is presented on entry). On rising edge, shift pad_cmd into rx register LSB first and increment bit count. After 8 rising edges, pulse cmd_valid, evaluate the byte (rules below), then go to ACK_WAIT, or to DONE if this was the last byte.
  - ACK_WAIT: counts ACK_DELAY clks, loads next tx byte, goes to ACK.
  - ACK: pad_ack_n=0 for ACK_WIDTH clks, then goes to SHIFT with byte_idx+1.
  - DONE: pad_dat_oe=0, pad_ack_n=1. Waits for att_n high, applies pending mode changes, goes to IDLE.
- Byte 0: command must be 0x01, else abort to DONE (no ack, no pending changes).
- Byte 1: response ID, selected in this priority order:
  - 0xF3 if config_mode=1;
  - 0x73 if mode_analog=1;
  - 0x41 otherwise.
  The command is latched as pkt_cmd. With config_mode=0 the only accepted commands are 0x42 and 0x43; any other command aborts to DONE.
- Byte 2: response 0x5A.
- Packet length: 3 + 2×ID[3:0] bytes, i.e. 5 for 0x41 and 9 for 0x73/0xF3. The last byte gets no ack.
- Data bytes (byte_idx 3+):
  - pkt_cmd 0x42, or 0x43 with config_mode=0: ~buttons[7:0], ~buttons[15:8], then analog RX, RY, LX, LY.
  - Any other command in config mode: 0x00.
- Config commands. The command value at byte_idx 3 is captured as pending:
  - 0x43: 0x01 sets pending config=1; 0x00 clears it.
  - 0x44 (config_mode=1 only): 0x01 sets pending analog=1; 0x00 sets 0. Other values leave the mode unchanged. The byte 4 lock value is ignored.
- Pending changes are applied in DONE only if every byte of the packet completed.
- Attention rises mid-packet (any state except IDLE): within 3 clks of the synchronised edge, release pad_dat_oe, set pad_ack_n=1, discard pending changes, return to IDLE.
- Asynchronous reset mid-packet returns all outputs to reset values immediately.
- Response bit timing: pad_dat changes only after a falling pad_clk edge and is stable for the following rising edge.

Test Plan:
- Digital poll: reset; host sends 01 42 00 00 00 with buttons=0x0003 -> data returns FF 41 5A FC FF; ack pulses after bytes 0–3 only, each ACK_WIDTH clks starting ACK_DELAY clks after the 8th rising edge; cmd_valid fires 5 times.
- Mode change: send 01 43 00 01 00 -> config_mode=1 after att_n rises. Send 01 44 00 01 03 00 00 00 00 -> ID F3, data all 00, mode_analog=1 after the packet. Send 01 43 00 00 5A×5 -> config_mode=0. Poll with analog=0x7F7F7F7F -> FF 73 5A + button bytes + 7F 7F 7F 7F.
- Bad header: first command byte 0x81 -> pad_dat_oe low within 1 byte time, no ack pulses, modes unchanged.
- Unknown command outside config: 01 45 ... -> aborts after byte 1 with ID still driven; no ack after byte 1.
- Attention abort: raise att_n mid-bit in byte 3 of a 0x44 packet -> dat_oe=0 and ack_n=1 within 3 clks; mode_analog unchanged; next packet is served normally.
- Async reset during ACK state -> pad_ack_n=1 and pad_dat_oe=0 immediately, modes cleared.
